// File: rtl/dpram_port_arbiter_if.sv
// Bus bundle between the requesters, the round-robin arbiter and one dpram port.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface dpram_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;

    logic                      rsp_valid;
    logic [IdW-1:0]            rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    logic                      ram_valid;
    logic                      ram_ready;
    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_data;
    logic [DATA_W-1:0]         ram_q;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_ready, ram_q,
        output req_ready, rsp_valid, rsp_id, rsp_data, ram_valid, ram_we, ram_addr, ram_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_ready, ram_q,
        input  req_ready, rsp_valid, rsp_id, rsp_data, ram_valid, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dpram port between NUM_REQ requesters; one request
// in flight at a time, read data returned on a tagged one-cycle response pulse.
module dpram_port_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    dpram_port_arbiter_if.slave bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e             state;
    logic [IdW-1:0]     rr_ptr;
    logic [IdW-1:0]     owner;
    logic [IdW-1:0]     winner;
    logic [IdW-1:0]     cand;
    logic [IdW-1:0]     next_ptr;
    logic               found;
    logic               grant;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IdW'(i)) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant         = rst_n && (state == StIdle) && found;
    assign bus.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
    assign next_ptr      = (owner == IdW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            rr_ptr        <= '0;
            owner         <= '0;
            bus.ram_valid <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_data  <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant) begin
                        bus.ram_we    <= sel_we;
                        bus.ram_addr  <= sel_addr;
                        bus.ram_data  <= sel_wdata;
                        bus.ram_valid <= 1'b1;
                        owner         <= winner;
                        state         <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.ram_ready) begin
                        bus.ram_valid <= 1'b0;
                        rr_ptr        <= next_ptr;
                        state         <= bus.ram_we ? StIdle : StResp;
                    end
                end
                StResp: begin
                    // ram_q is valid in the cycle after the read handshake.
                    bus.rsp_data  <= bus.ram_q;
                    bus.rsp_id    <= owner;
                    bus.rsp_valid <= 1'b1;
                    state         <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
Round-robin arbiter that shares one port (A or B) of the dpram between NUM_REQ independent requesters.
It accepts one request at a time over per-requester valid/ready and drives the dpram port handshake (addr/data/we/valid/ready).
For reads it captures q and returns it on a tagged response channel.
One instance sits in front of each dpram port, between bus-side masters and the RAM.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, dpram address width
DATA_W, 8, dpram data width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_we  input  NUM_REQ  per-requester write enable (1=write, 0=read)
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing
rsp_valid  output  1  read response valid, 1-cycle pulse
rsp_id  output  $clog2(NUM_REQ)  requester index owning the response
rsp_data  output  DATA_W  read data
ram_valid  output  1  to dpram valid_x
ram_ready  input  1  from dpram ready_x
ram_we  output  1  to dpram we_x
ram_addr  output  ADDR_W  to dpram addr_x
ram_data  output  DATA_W  to dpram data_x
ram_q  input  DATA_W  from dpram q_x

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, ram_valid=0, ram_we=0, ram_addr=0, ram_data=0, rsp_valid=0, rsp_id=0, rsp_data=0. req_ready=0 during reset.
- Downstream contract:
  - dpram accepts on a posedge where ram_valid&&ram_ready.
  - ram_q is valid in the cycle following that edge (1-cycle read latency).
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally, all other req_ready bits 0. req_ready is 0 in ISSUE and RESP.
  - At the edge: register winner's we/addr/wdata into ram_we/ram_addr/ram_data, set ram_valid=1, latch owner id, go to ISSUE.
  - With no req_valid, stay in IDLE with ram_valid=0.
- ISSUE:
  - ram_valid=1; ram_we/addr/data held stable until the handshake.
  - On ram_valid&&ram_ready: ram_valid<=0 and rr_ptr<=(owner+1) mod NUM_REQ.
  - Write: go to IDLE, no response.
  - Read: go to RESP.
- RESP:
  - rsp_data<=ram_q, rsp_id<=owner, rsp_valid<=1 for exactly one cycle; go to IDLE.
  - The new IDLE arbitration can grant in the same cycle that rsp_valid is high.
- Latency, request accepted at edge E0 and ram_ready=1:
  - RAM handshake at E1.
  - Read: rsp_valid high E2..E3.
  - Write: next grant possible at E2.
- Throughput: write 1 per 2 cycles, read 1 per 3 cycles.
- rsp_valid defaults to 0 every cycle it is not being set.
- Fairness: a requester holding req_valid is granted within NUM_REQ grants.
- ram_ready low: stay in ISSUE indefinitely, outputs stable, no timeout.
- req_valid deasserted by a requester before grant: no effect, no latching.
- Index wrap: rr_ptr=NUM_REQ-1 and requester NUM_REQ-1 granted gives rr_ptr=0.
- Reset mid-operation (any state): in-flight request dropped, no rsp_valid, ram_valid falls immediately.

Test Plan:
- Single read: req_valid=0001, we=0, addr[0]=0x10, RAM holds 0xA5 at 0x10, ram_ready=1 -> req_ready=0001 at E0, ram_valid/ram_addr=0x10 E0..E1, rsp_valid=1, rsp_id=0, rsp_data=0xA5 at E2.
- Write then read back: requester 2 writes 0x3C to 0x44, then reads 0x44 -> no rsp after the write; read returns rsp_id=2, rsp_data=0x3C.
- Round-robin: req_valid=1111 held, all reads -> grant order 0,1,2,3,0,1; rsp_id follows that order; never two req_ready bits high.
- Backpressure: ram_ready=0 for 5 cycles during ISSUE -> ram_valid, ram_addr, ram_data and ram_we stable for 5 cycles; req_ready=0000 throughout; completes when ram_ready=1.
- Reset mid-RESP: assert rst_n=0 while in RESP -> rsp_valid never pulses, all outputs 0 immediately; after release, req_valid=1000 is granted first with rr_ptr=0 scan (requester 3 granted since it is the only one valid).
- Wrap: last grant to requester 3, then req_valid=1001 -> requester 0 granted.
